// File: rtl/ascon_pkg.sv
// Shared constants and types for the ASCON wrapper bus master: register map,
// sequencer states and mode encodings.
package ascon_pkg;

    localparam int ASC_ADDR_W      = 5;
    localparam int ASC_CTRL_ADDR   = 0;
    localparam int ASC_DATA_BASE   = 1;
    localparam int ASC_WORDS_IN    = 16;
    localparam int ASC_STATUS_ADDR = 17;
    localparam int ASC_RESULT_BASE = 18;
    localparam int ASC_WORDS_OUT   = 8;
    localparam int ASC_POLL_GAP    = 4;
    localparam int ASC_TIMEOUT     = 1023;

    localparam logic [1:0] MODE_ENC = 2'd0;
    localparam logic [1:0] MODE_DEC = 2'd1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        CLEAR,
        POLL,
        FETCH
    } seq_state_e;

    // Control register image: {29'b0, mode[1:0], start}.
    function automatic logic [31:0] ctrl_word(input logic [1:0] mode, input logic start);
        return {29'b0, mode, start};
    endfunction

endpackage

// File: rtl/ascon_avmm_rd_buf.sv
// Single-entry result register between the wrapper read port and the
// valid/ready result stream; holds its word until the sink takes it.
module ascon_avmm_rd_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_data,
    input  logic        load_last,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        out_last
);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value of its inputs regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/ascon_avmm_sequencer.sv
// Avalon-MM master that loads one ASCON job into the wrapper, pulses start,
// polls for done and streams the result words out on a valid/ready port.
module ascon_avmm_sequencer
    import ascon_pkg::*;
#(
    parameter int ADDR_W      = ASC_ADDR_W,
    parameter int CTRL_ADDR   = ASC_CTRL_ADDR,
    parameter int DATA_BASE   = ASC_DATA_BASE,
    parameter int WORDS_IN    = ASC_WORDS_IN,
    parameter int STATUS_ADDR = ASC_STATUS_ADDR,
    parameter int RESULT_BASE = ASC_RESULT_BASE,
    parameter int WORDS_OUT   = ASC_WORDS_OUT,
    parameter int POLL_GAP    = ASC_POLL_GAP,
    parameter int TIMEOUT     = ASC_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic              out_last,
    output logic              busy,
    output logic              error,
    output logic              chipselect,
    output logic              write,
    output logic              read,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata
);

    localparam int IDX_W  = $clog2(WORDS_IN + 1);
    localparam int K_W    = $clog2(WORDS_OUT + 1);
    localparam int POLL_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = $clog2(POLL_GAP + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(WORDS_IN - 1);
    localparam logic [K_W-1:0]    K_END     = K_W'(WORDS_OUT);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(POLL_GAP);

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(CTRL_ADDR);
    localparam logic [ADDR_W-1:0] A_DATA   = ADDR_W'(DATA_BASE);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(STATUS_ADDR);
    localparam logic [ADDR_W-1:0] A_RESULT = ADDR_W'(RESULT_BASE);

    seq_state_e        state, state_n;
    logic [1:0]        mode, mode_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [K_W-1:0]    k, k_n;
    logic [POLL_W-1:0] poll_cnt, poll_cnt_n;
    logic [GAP_W-1:0]  gap, gap_n;
    logic              error_n;
    logic              rd_sample;

    logic              wr_n, rd_n;
    logic [ADDR_W-1:0] addr_n;
    logic [31:0]       wdata_n;
    logic              buf_load, buf_last;

    assign cmd_ready = (state == IDLE);
    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE);

    // Only one read is ever in flight, so the captured word is index k-1.
    assign buf_last = (k == K_END);

    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        mode_n     = mode;
        idx_n      = idx;
        k_n        = k;
        poll_cnt_n = poll_cnt;
        gap_n      = gap;
        error_n    = error;
        wr_n       = 1'b0;
        rd_n       = 1'b0;
        addr_n     = '0;
        wdata_n    = '0;
        buf_load   = 1'b0;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_n    = LOAD;
                    mode_n     = cmd_mode;
                    error_n    = 1'b0;
                    idx_n      = '0;
                    k_n        = '0;
                    poll_cnt_n = '0;
                    gap_n      = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    wr_n    = 1'b1;
                    addr_n  = A_DATA + ADDR_W'(idx);
                    wdata_n = in_data;
                    idx_n   = idx + 1'b1;
                    if (idx == IDX_LAST) state_n = START;
                end
            end
            START: begin
                wr_n    = 1'b1;
                addr_n  = A_CTRL;
                wdata_n = ctrl_word(mode, 1'b1);
                state_n = CLEAR;
            end
            CLEAR: begin
                wr_n    = 1'b1;
                addr_n  = A_CTRL;
                wdata_n = ctrl_word(mode, 1'b0);
                state_n = POLL;
            end
            POLL: begin
                if (gap != '0) gap_n = gap - 1'b1;
                if (rd_sample) begin
                    if (readdata[0]) begin
                        state_n = FETCH;
                    end else if (poll_cnt == POLL_LAST) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        poll_cnt_n = poll_cnt + 1'b1;
                    end
                end else if (!read && gap == '0) begin
                    // Gap counts from issue, giving POLL_GAP idle cycles between reads.
                    rd_n   = 1'b1;
                    addr_n = A_STATUS;
                    gap_n  = GAP_LOAD;
                end
            end
            FETCH: begin
                if (rd_sample) begin
                    buf_load = 1'b1;
                end else if (!read && k != K_END && (!out_valid || out_ready)) begin
                    rd_n   = 1'b1;
                    addr_n = A_RESULT + ADDR_W'(k);
                    k_n    = k + 1'b1;
                end
                if (out_valid && out_ready && out_last) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode       <= MODE_ENC;
            idx        <= '0;
            k          <= '0;
            poll_cnt   <= '0;
            gap        <= '0;
            error      <= 1'b0;
            rd_sample  <= 1'b0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            read       <= 1'b0;
            address    <= '0;
            writedata  <= '0;
        end else begin
            state      <= state_n;
            mode       <= mode_n;
            idx        <= idx_n;
            k          <= k_n;
            poll_cnt   <= poll_cnt_n;
            gap        <= gap_n;
            error      <= error_n;
            rd_sample  <= read;
            chipselect <= wr_n | rd_n;
            write      <= wr_n;
            read       <= rd_n;
            address    <= addr_n;
            writedata  <= wdata_n;
        end
    end

    ascon_avmm_rd_buf u_rd_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_data (readdata),
        .load_last (buf_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last)
    );

endmodule
